// File: rtl/pc_seq_pkg.sv
// Package: pc_seq_pkg
// Shared constants and types for the program-counter sequencer.
//   TYPE_*  : decoded instruction-class codes (types input)
//   OP_*    : opcode values that select jump / branch behaviour
//   state_e : sequencer run state, also exported on the debug port
package pc_seq_pkg;

    localparam logic [1:0] TYPE_JUMP   = 2'b10;
    localparam logic [1:0] TYPE_BRANCH = 2'b11;

    localparam logic [3:0] OP_JMP   = 4'b0011;
    localparam logic [3:0] OP_BEQNE = 4'b0100;
    localparam logic [3:0] OP_BLTGE = 4'b0101;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

endpackage

// File: rtl/return_addr_stack.sv
// Module: return_addr_stack
// Circular return-address stack. A push while full overwrites the oldest
// entry and leaves the count saturated at DEPTH. Push has priority over pop;
// a pop while empty is ignored.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the stack)
//   push_i        write push_data_i as the new top
//   pop_i         discard the current top
//   push_data_i   value to push
//   top_o         current top (meaningful only when !empty_o)
//   count_o       occupancy, 0..DEPTH
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
module return_addr_stack #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           push_data_i,
    output logic [WIDTH-1:0]           top_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q;     // next free slot; top lives at sp_q-1
    logic [PTR_W-1:0] sp_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    // DEPTH is a power of two, so the pointer wraps naturally.
    assign top_o   = mem_q[sp_q - PTR_W'(1)];

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push_i) begin
            sp_d = sp_q + PTR_W'(1);
            if (!full_o) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            sp_d  = sp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (!rst && push_i) begin
            mem_q[sp_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Module: pc_sequencer
// Registered program-counter sequencer. Each unstalled cycle in RUN it picks
// the next PC from call / return / jump / branch / sequential, keeps a
// return-address stack for call/ret, and enters a sticky HALT on program_end.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall           hold pc, RAS and flags for this cycle
//   types, opcode   decoded instruction class / opcode
//   is_call/is_ret  decoded call / return
//   program_end     end-of-program marker (enters HALT)
//   readdata1/2     branch compare operands
//   jump_addr       jump / call target
//   branch_addr     [BR_W-1:1] branch target, [0] condition select
//   pc              current PC (drives imem address)
//   redirect        1 for the cycle after a non-sequential commit
//   halted          sticky halt indication
//   ras_count       return-stack occupancy
//   ras_overflow    sticky: call pushed while stack full
//   ras_underflow   sticky: ret issued while stack empty
//   dbg_state       current FSM state
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = 19,
    parameter int              DATA_W    = 19,
    parameter int              JUMP_W    = 11,
    parameter int              BR_W      = 8,
    parameter int              RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              EXT_COND  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [1:0]                   types,
    input  logic [3:0]                   opcode,
    input  logic                         is_call,
    input  logic                         is_ret,
    input  logic                         program_end,
    input  logic [DATA_W-1:0]            readdata1,
    input  logic [DATA_W-1:0]            readdata2,
    input  logic [JUMP_W-1:0]            jump_addr,
    input  logic [BR_W-1:0]              branch_addr,
    output logic [PC_W-1:0]              pc,
    output logic                         redirect,
    output logic                         halted,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output state_e                       dbg_state
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    state_e          state_q, state_d;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jmp_target;
    logic [PC_W-1:0] br_target;
    logic            ops_eq;
    logic            ops_lt;
    logic            is_jmp;
    logic            is_beqne;
    logic            is_bltge;
    logic            br_taken;

    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_full;
    logic            ras_empty;

    return_addr_stack #(
        .WIDTH (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .full_o      (ras_full),
        .empty_o     (ras_empty)
    );

    assign pc_inc     = pc_q + PC_W'(1);
    assign jmp_target = PC_W'(jump_addr);
    assign br_target  = PC_W'(branch_addr[BR_W-1:1]);

    assign ops_eq   = (readdata1 == readdata2);
    assign ops_lt   = ($signed(readdata1) < $signed(readdata2));

    assign is_jmp   = (types == TYPE_JUMP)   && (opcode == OP_JMP);
    assign is_beqne = (types == TYPE_BRANCH) && (opcode == OP_BEQNE);
    assign is_bltge = (EXT_COND != 0) && (types == TYPE_BRANCH) && (opcode == OP_BLTGE);

    // Condition bit 0 selects the base compare, 1 selects its inverse
    // (eq/ne, lt/ge).
    always_comb begin
        br_taken = 1'b0;
        if (is_beqne) begin
            br_taken = ops_eq ^ branch_addr[0];
        end else if (is_bltge) begin
            br_taken = ops_lt ^ branch_addr[0];
        end
    end

    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        state_d    = state_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;

        if (state_q == RUN && !stall) begin
            if (program_end) begin
                state_d = HALT;
            end else if (is_call) begin
                // Call wins over a simultaneous ret; nothing is popped.
                pc_d       = jmp_target;
                redirect_d = 1'b1;
                ras_push   = 1'b1;
                if (ras_full) begin
                    ovf_d = 1'b1;
                end
            end else if (is_ret) begin
                if (ras_empty) begin
                    // No return address available: fall through sequentially.
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else begin
                    pc_d       = ras_top;
                    redirect_d = 1'b1;
                    ras_pop    = 1'b1;
                end
            end else if (is_jmp) begin
                pc_d       = jmp_target;
                redirect_d = 1'b1;
            end else if (br_taken) begin
                pc_d       = br_target;
                redirect_d = 1'b1;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            state_q    <= RUN;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign pc            = pc_q;
    assign redirect      = redirect_q;
    assign halted        = (state_q == HALT);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign dbg_state     = state_q;

endmodule
